// File: rtl/rgmii_rx_align.sv
// rgmii_rx_align: RGMII DDR samples to GMII bytes (byte/nibble modes, ports clk rst rxd_q1/q2 rx_ctl_q1/q2 mii_select -> gmii_rxd/dv/er/valid) plus filtered in-band link status
module rgmii_rx_align #(
  parameter int STATUS_FILTER = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       rx_ctl_q1,
  input  logic       rx_ctl_q2,
  input  logic       mii_select,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_rx_valid,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_full_duplex
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  localparam logic [3:0] FL = 4'(STATUS_FILTER);
  state_t state_q, state_d;
  logic [3:0] lo_q, lo_d, cnt_q, cnt_d, last_q, last_d;
  logic [7:0] rxd_q, rxd_d;
  logic [1:0] spd_q, spd_d;
  logic er_lo_q, er_lo_d, tog_q, tog_d, dv_q, dv_d, er_q, er_d, vld_q, vld_d;
  logic link_q, link_d, fdx_q, fdx_d, sel_q;
  logic dv, er, chg, ok, upd;
  always_comb begin
    dv = rx_ctl_q1;
    er = rx_ctl_q1 ^ rx_ctl_q2;
    chg = mii_select != sel_q;
    state_d = IDLE;
    lo_d = lo_q;
    er_lo_d = er_lo_q;
    tog_d = 1'b0;
    rxd_d = 8'h00;
    dv_d = 1'b0;
    er_d = 1'b0;
    vld_d = 1'b0;
    if (chg) begin
      state_d = IDLE;
    end else if (!mii_select) begin
      rxd_d = {rxd_q2, rxd_q1};
      dv_d = dv;
      er_d = er;
      vld_d = 1'b1;
    end else if (state_q == LO) begin
      vld_d = 1'b1;
      dv_d = 1'b1;
      rxd_d = dv ? {rxd_q1, lo_q} : {4'h0, lo_q};
      er_d = dv ? (er | er_lo_q) : 1'b1;
      state_d = dv ? HI : IDLE;
    end else if (dv) begin
      state_d = LO;
      lo_d = rxd_q1;
      er_lo_d = er;
    end else begin
      vld_d = tog_q;
      er_d = er & tog_q;
      tog_d = ~tog_q;
    end
    ok = !dv && !er && rxd_q1[2:1] != 2'b11;
    cnt_d = !ok ? 4'd0 :
            (cnt_q != 4'd0 && rxd_q1 == last_q) ? ((cnt_q == FL) ? FL : cnt_q + 4'd1) : 4'd1;
    last_d = ok ? rxd_q1 : last_q;
    upd = ok && cnt_d == FL;
    link_d = upd ? rxd_q1[0] : link_q;
    spd_d = upd ? rxd_q1[2:1] : spd_q;
    fdx_d = upd ? rxd_q1[3] : fdx_q;
  end
  always_ff @(posedge clk) begin
    sel_q <= mii_select;
    if (rst) begin
      state_q <= IDLE;
      lo_q <= 4'h0;
      er_lo_q <= 1'b0;
      tog_q <= 1'b0;
      rxd_q <= 8'h00;
      dv_q <= 1'b0;
      er_q <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= 4'd0;
      last_q <= 4'h0;
      link_q <= 1'b0;
      spd_q <= 2'b00;
      fdx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      er_lo_q <= er_lo_d;
      tog_q <= tog_d;
      rxd_q <= rxd_d;
      dv_q <= dv_d;
      er_q <= er_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      link_q <= link_d;
      spd_q <= spd_d;
      fdx_q <= fdx_d;
    end
  end
  assign gmii_rxd = rxd_q;
  assign gmii_rx_dv = dv_q;
  assign gmii_rx_er = er_q;
  assign gmii_rx_valid = vld_q;
  assign link_up = link_q;
  assign link_speed = spd_q;
  assign link_full_duplex = fdx_q;
endmodule

// File: tb/tb_rgmii_rx_align.sv
// tb_rgmii_rx_align: scoreboard bench with directed and random RGMII traffic against a frame-level model
module tb_rgmii_rx_align;
  localparam int F = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] rxd_q1 = 4'h0, rxd_q2 = 4'h0;
  logic rx_ctl_q1 = 1'b0, rx_ctl_q2 = 1'b0, mii_select = 1'b0;
  logic [7:0] gmii_rxd;
  logic gmii_rx_dv, gmii_rx_er, gmii_rx_valid, link_up, link_full_duplex;
  logic [1:0] link_speed;
  rgmii_rx_align #(.STATUS_FILTER(F)) dut (
    .clk(clk), .rst(rst), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2),
    .rx_ctl_q1(rx_ctl_q1), .rx_ctl_q2(rx_ctl_q2), .mii_select(mii_select),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_rx_valid(gmii_rx_valid), .link_up(link_up), .link_speed(link_speed),
    .link_full_duplex(link_full_duplex)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0;
  bit started = 0;
  logic [9:0] exp_q[$];
  logic [4:0] nib[$];
  logic [3:0] hist[$];
  int idle_n = 0;
  logic prev_sel = 1'b0;
  logic e_zero = 1'b1, e_link = 1'b0, e_fdx = 1'b0;
  logic [1:0] e_spd = 2'b00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic model(input logic [3:0] a, input logic [3:0] b, input logic c1, input logic c2, input logic s, input logic r);
    logic dv, er, same;
    if (r) begin
      nib.delete();
      hist.delete();
      idle_n = 0;
      {e_link, e_spd, e_fdx} = 4'h0;
      e_zero = 1'b1;
      prev_sel = s;
      return;
    end
    e_zero = 1'b0;
    dv = c1;
    er = c1 ^ c2;
    if (!dv && !er && a[2:1] != 2'b11) begin
      hist.push_back(a);
      if (hist.size() > F) void'(hist.pop_front());
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != a) same = 1'b0;
      if (hist.size() == F && same) begin
        e_link = a[0];
        e_spd = a[2:1];
        e_fdx = a[3];
      end
    end else hist.delete();
    if (s != prev_sel) begin
      nib.delete();
      idle_n = 0;
    end else if (!s) begin
      exp_q.push_back({b, a, dv, er});
      idle_n = 0;
    end else if (dv) begin
      nib.push_back({er, a});
      idle_n = 0;
      if (nib.size() == 2) begin
        exp_q.push_back({nib[1][3:0], nib[0][3:0], 1'b1, nib[0][4] | nib[1][4]});
        nib.delete();
      end
    end else if (nib.size() == 1) begin
      exp_q.push_back({4'h0, nib[0][3:0], 1'b1, 1'b1});
      nib.delete();
      idle_n = 0;
    end else begin
      idle_n++;
      if (idle_n % 2 == 0) exp_q.push_back({8'h00, 1'b0, er});
    end
    prev_sel = s;
  endtask
  task automatic cyc(input logic [3:0] a, input logic [3:0] b, input logic c1, input logic c2, input logic s, input logic r);
    @(negedge clk);
    rxd_q1 = a;
    rxd_q2 = b;
    rx_ctl_q1 = c1;
    rx_ctl_q2 = c2;
    mii_select = s;
    rst = r;
    model(a, b, c1, c2, s, r);
    started = 1;
  endtask
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (e_zero)
          chk("reset_zero", {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid}, 11'h0);
        chk("status", {link_up, link_speed, link_full_duplex}, {e_link, e_spd, e_fdx});
        if (gmii_rx_valid) begin
          if (exp_q.size() == 0) chk("unexpected_strobe", {gmii_rxd, gmii_rx_dv, gmii_rx_er}, 10'h3ff ^ {gmii_rxd, gmii_rx_dv, gmii_rx_er});
          else begin
            e = exp_q.pop_front();
            chk("data", {gmii_rxd, gmii_rx_dv, gmii_rx_er}, e);
          end
        end
      end
    end
  end
  initial begin
    logic s;
    logic [3:0] v;
    logic [3:0] ns[6];
    ns = '{4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2};
    repeat (3) cyc(4'h0, 4'h0, 0, 0, 0, 1);
    repeat (8) cyc(4'h5, 4'h5, 1, 1, 0, 0);
    cyc(4'hD, 4'h5, 1, 1, 0, 0);
    cyc(4'h3, 4'hC, 1, 1, 0, 0);
    cyc(4'h6, 4'h9, 1, 0, 0, 0);
    cyc(4'h1, 4'h2, 1, 1, 0, 0);
    cyc(4'h4, 4'hF, 0, 1, 0, 0);
    repeat (3) cyc(4'h0, 4'h0, 0, 0, 0, 0);
    repeat (3) cyc(4'h0, 4'h0, 0, 0, 1, 0);
    foreach (ns[i]) cyc(ns[i], 4'h0, 1, 1, 1, 0);
    repeat (4) cyc(4'h0, 4'h0, 0, 0, 1, 0);
    cyc(4'hA, 4'h0, 1, 1, 1, 0);
    cyc(4'hB, 4'h0, 1, 1, 1, 0);
    cyc(4'hC, 4'h0, 1, 1, 1, 0);
    repeat (4) cyc(4'h0, 4'h0, 0, 0, 1, 0);
    cyc(4'h3, 4'h0, 1, 1, 1, 0);
    cyc(4'h0, 4'h0, 0, 0, 1, 1);
    repeat (3) cyc(4'h0, 4'h0, 0, 0, 1, 0);
    cyc(4'hD, 4'h0, 0, 0, 1, 0);
    cyc(4'h1, 4'h0, 1, 1, 1, 0);
    cyc(4'h1, 4'h0, 1, 1, 1, 0);
    repeat (2) cyc(4'hD, 4'h0, 0, 0, 1, 0);
    repeat (5) cyc(4'h7, 4'h0, 0, 0, 1, 0);
    cyc(4'hE, 4'h0, 0, 0, 1, 0);
    cyc(4'h2, 4'h0, 1, 1, 1, 0);
    cyc(4'h9, 4'hE, 1, 1, 0, 0);
    cyc(4'hE, 4'h0, 1, 1, 1, 0);
    cyc(4'h4, 4'h0, 1, 1, 1, 0);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    s = 1'b1;
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom % 10)
        0: cyc(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), s, 1);
        1: begin
          s = ~s;
          cyc(4'($urandom), 4'($urandom), 1, 1, s, 0);
        end
        2, 3, 4, 5: repeat (1 + $urandom % 9)
          cyc(4'($urandom), 4'($urandom), 1, ($urandom % 8) != 0, s, 0);
        default: begin
          v = ($urandom % 4 == 0) ? 4'hD : ($urandom % 3 == 0) ? 4'h7 : ($urandom % 2 == 0) ? 4'h2 : 4'($urandom);
          repeat (1 + $urandom % 6) cyc(v, 4'($urandom), 0, ($urandom % 10) == 0, s, 0);
        end
      endcase
    end
    repeat (4) cyc(4'h0, 4'h0, 0, 0, s, 0);
    @(posedge clk);
    #2;
    started = 0;
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
